// File: rtl/turn_sequencer.sv
// Turn sequencer for a two-player 3x3 attack game: menu configuration, human/CPU turns,
// turn timeout, board handshake and game-over handling.
module turn_sequencer #(
    parameter int unsigned TURN_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_select,
    input  logic       i_move,
    input  logic       i_attack,
    input  logic       i_cant_player,
    input  logic       i_orden,
    input  logic       i_cpu_valid,
    input  logic [1:0] i_cpu_row,
    input  logic [1:0] i_cpu_col,
    input  logic       i_board_done,
    input  logic [1:0] i_winner,
    output logic       o_attack_req,
    output logic [1:0] o_row_out,
    output logic [1:0] o_col_out,
    output logic [1:0] o_current_player_out,
    output logic [3:0] o_estado,
    output logic [7:0] o_timer_out
);

    typedef enum logic [3:0] {
        StIdle       = 4'd0,
        StCfgPlayers = 4'd1,
        StCfgOrder   = 4'd2,
        StTurn       = 4'd3,
        StWaitBoard  = 4'd4,
        StCheck      = 4'd5,
        StGameOver   = 4'd6
    } state_e;

    localparam logic [7:0] TimerLast = 8'(TURN_CYCLES - 1);

    state_e     r_state;
    logic       r_attack_req;
    logic [1:0] r_row;
    logic [1:0] r_col;
    logic [1:0] r_player;
    logic [7:0] r_timer;
    logic       r_cant;
    logic [1:0] r_winner;

    logic       r_sel_prev;
    logic       r_move_prev;
    logic       r_atk_prev;
    logic       r_rst_q;

    logic       w_sel_edge;
    logic       w_move_edge;
    logic       w_atk_edge;
    logic       w_cpu_turn;
    logic [1:0] w_next_row;
    logic [1:0] w_next_col;
    logic [1:0] w_cpu_row;
    logic [1:0] w_cpu_col;

    // The cycle right after reset is blanked so a button held through reset is not an edge.
    always_ff @(posedge i_clk) begin
        r_rst_q <= i_rst;
        if (i_rst) begin
            r_sel_prev  <= 1'b0;
            r_move_prev <= 1'b0;
            r_atk_prev  <= 1'b0;
        end else begin
            r_sel_prev  <= i_select;
            r_move_prev <= i_move;
            r_atk_prev  <= i_attack;
        end
    end

    assign w_sel_edge  = i_select & ~r_sel_prev  & ~r_rst_q;
    assign w_move_edge = i_move   & ~r_move_prev & ~r_rst_q;
    assign w_atk_edge  = i_attack & ~r_atk_prev  & ~r_rst_q;

    assign w_cpu_turn  = r_cant & (r_player == 2'd2);

    assign w_next_col  = (r_col == 2'd3) ? 2'd1 : r_col + 2'd1;
    assign w_next_row  = (r_col != 2'd3) ? r_row : ((r_row == 2'd3) ? 2'd1 : r_row + 2'd1);

    assign w_cpu_row   = (i_cpu_row == 2'd0) ? 2'd1 : i_cpu_row;
    assign w_cpu_col   = (i_cpu_col == 2'd0) ? 2'd1 : i_cpu_col;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_attack_req <= 1'b0;
            r_row        <= 2'd1;
            r_col        <= 2'd1;
            r_player     <= 2'd0;
            r_timer      <= 8'd0;
            r_cant       <= 1'b0;
            r_winner     <= 2'd0;
        end else begin
            r_attack_req <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_sel_edge) begin
                        r_state <= StCfgPlayers;
                    end
                end
                StCfgPlayers: begin
                    if (w_sel_edge) begin
                        r_cant  <= i_cant_player;
                        r_state <= StCfgOrder;
                    end
                end
                StCfgOrder: begin
                    if (w_sel_edge) begin
                        r_player <= i_orden ? 2'd2 : 2'd1;
                        r_row    <= 2'd1;
                        r_col    <= 2'd1;
                        r_timer  <= 8'd0;
                        r_state  <= StTurn;
                    end
                end
                StTurn: begin
                    if (w_cpu_turn) begin
                        r_timer <= 8'd0;
                        if (i_cpu_valid) begin
                            r_row        <= w_cpu_row;
                            r_col        <= w_cpu_col;
                            r_attack_req <= 1'b1;
                            r_state      <= StWaitBoard;
                        end
                    end else if (w_atk_edge || (r_timer >= TimerLast)) begin
                        // Attack beats a same-cycle move; the timer freezes at its last value.
                        r_attack_req <= 1'b1;
                        r_state      <= StWaitBoard;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                        if (w_move_edge) begin
                            r_row <= w_next_row;
                            r_col <= w_next_col;
                        end
                    end
                end
                StWaitBoard: begin
                    if (i_board_done) begin
                        r_winner <= i_winner;
                        r_state  <= StCheck;
                    end
                end
                StCheck: begin
                    if (r_winner != 2'd0) begin
                        r_state <= StGameOver;
                    end else begin
                        r_player <= (r_player == 2'd1) ? 2'd2 : 2'd1;
                        r_row    <= 2'd1;
                        r_col    <= 2'd1;
                        r_timer  <= 8'd0;
                        r_state  <= StTurn;
                    end
                end
                StGameOver: begin
                    if (w_sel_edge) begin
                        r_player <= 2'd0;
                        r_row    <= 2'd1;
                        r_col    <= 2'd1;
                        r_timer  <= 8'd0;
                        r_state  <= StIdle;
                    end
                end
                default: begin
                    r_player <= 2'd0;
                    r_state  <= StIdle;
                end
            endcase
        end
    end

    assign o_attack_req         = r_attack_req;
    assign o_row_out            = r_row;
    assign o_col_out            = r_col;
    assign o_current_player_out = r_player;
    assign o_estado             = r_state;
    assign o_timer_out          = r_timer;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer; attack_req targets are checked against a scoreboard queue.
module tb_turn_sequencer;

    logic       clk = 1'b0;
    logic       rst_main, rst_long;
    logic       select, move, attack, cant, orden, cpu_valid, board_done;
    logic [1:0] cpu_row, cpu_col, winner;

    logic       d_req, l_req;
    logic [1:0] d_row, d_col, d_ply, l_row, l_col, l_ply;
    logic [3:0] d_est, l_est;
    logic [7:0] d_tmr, l_tmr;

    logic       sel_long;
    logic       w_req;
    logic [1:0] w_row, w_col, w_ply;
    logic [3:0] w_est;
    logic [7:0] w_tmr;

    int         vectors = 0;
    int         miscompares = 0;
    logic       prev_req = 1'b0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    turn_sequencer #(.TURN_CYCLES(16)) u_dut (
        .i_clk(clk), .i_rst(rst_main), .i_select(select), .i_move(move), .i_attack(attack),
        .i_cant_player(cant), .i_orden(orden), .i_cpu_valid(cpu_valid), .i_cpu_row(cpu_row),
        .i_cpu_col(cpu_col), .i_board_done(board_done), .i_winner(winner),
        .o_attack_req(d_req), .o_row_out(d_row), .o_col_out(d_col),
        .o_current_player_out(d_ply), .o_estado(d_est), .o_timer_out(d_tmr)
    );

    // Long-timeout copy so a full nine-step cursor walk fits in one human turn.
    turn_sequencer #(.TURN_CYCLES(64)) u_long (
        .i_clk(clk), .i_rst(rst_long), .i_select(select), .i_move(move), .i_attack(attack),
        .i_cant_player(cant), .i_orden(orden), .i_cpu_valid(cpu_valid), .i_cpu_row(cpu_row),
        .i_cpu_col(cpu_col), .i_board_done(board_done), .i_winner(winner),
        .o_attack_req(l_req), .o_row_out(l_row), .o_col_out(l_col),
        .o_current_player_out(l_ply), .o_estado(l_est), .o_timer_out(l_tmr)
    );

    assign w_req = sel_long ? l_req : d_req;
    assign w_row = sel_long ? l_row : d_row;
    assign w_col = sel_long ? l_col : d_col;
    assign w_ply = sel_long ? l_ply : d_ply;
    assign w_est = sel_long ? l_est : d_est;
    assign w_tmr = sel_long ? l_tmr : d_tmr;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled on the falling edge and attack pulses scored.
    task automatic cyc();
        logic [3:0] e;
        @(posedge clk);
        @(negedge clk);
        if (w_req) begin
            check("req_not_consecutive", {15'd0, prev_req}, 16'd0);
            if (exp_q.size() == 0) begin
                check("req_unexpected", {15'd0, w_req}, 16'd0);
            end else begin
                e = exp_q.pop_front();
                check("req_target", {12'd0, w_row, w_col}, {12'd0, e});
            end
        end
        prev_req = w_req;
    endtask

    task automatic press(input int which);
        if (which == 0) select = 1'b1;
        else if (which == 1) move = 1'b1;
        else attack = 1'b1;
        cyc();
        select = 1'b0;
        move   = 1'b0;
        attack = 1'b0;
        cyc();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_estado"}, 16'(w_est), 16'd0);
        check({tag, "_req"}, 16'(w_req), 16'd0);
        check({tag, "_row"}, 16'(w_row), 16'd1);
        check({tag, "_col"}, 16'(w_col), 16'd1);
        check({tag, "_player"}, 16'(w_ply), 16'd0);
        check({tag, "_timer"}, 16'(w_tmr), 16'd0);
    endtask

    initial begin
        int n;
        int wrap_row[9] = '{1, 1, 2, 2, 2, 3, 3, 3, 1};
        int wrap_col[9] = '{2, 3, 1, 2, 3, 1, 2, 3, 1};

        sel_long = 1'b0;
        rst_main = 1'b1;
        rst_long = 1'b1;
        select = 1'b1; move = 1'b0; attack = 1'b0; cant = 1'b0; orden = 1'b0;
        cpu_valid = 1'b0; cpu_row = 2'd0; cpu_col = 2'd0; board_done = 1'b0; winner = 2'd0;

        // Reset state, with select held across reset release
        cyc();
        cyc();
        check_reset("reset");
        rst_main = 1'b0;
        cyc(); cyc(); cyc();
        check("held_select_no_event", 16'(w_est), 16'd0);
        select = 1'b0;
        cyc();
        check("held_select_release", 16'(w_est), 16'd0);

        // Configuration: human vs CPU, player 2 starts
        cant = 1'b1; orden = 1'b1;
        press(0); check("cfg_players", 16'(w_est), 16'd1);
        press(0); check("cfg_order", 16'(w_est), 16'd2);
        press(0); check("cfg_turn", 16'(w_est), 16'd3);
        check("cfg_player2", 16'(w_ply), 16'd2);
        cant = 1'b0; orden = 1'b0;
        press(1);
        press(2);
        check("cpu_ignores_buttons_est", 16'(w_est), 16'd3);
        check("cpu_ignores_buttons_col", 16'(w_col), 16'd1);
        check("cpu_timer_held", 16'(w_tmr), 16'd0);

        // CPU attack at (2,3), no winner
        cpu_valid = 1'b1; cpu_row = 2'd2; cpu_col = 2'd3;
        exp_q.push_back({2'd2, 2'd3});
        cyc();
        cpu_valid = 1'b0;
        check("cpu_row", 16'(w_row), 16'd2);
        check("cpu_col", 16'(w_col), 16'd3);
        check("cpu_wait", 16'(w_est), 16'd4);
        cyc();
        check("wait_hold", 16'(w_est), 16'd4);
        board_done = 1'b1; winner = 2'd0;
        cyc();
        board_done = 1'b0;
        check("check_state", 16'(w_est), 16'd5);
        cyc();
        check("toggle_turn", 16'(w_est), 16'd3);
        check("toggle_player1", 16'(w_ply), 16'd1);
        check("turn_entry_timer", 16'(w_tmr), 16'd0);
        check("turn_entry_row", 16'(w_row), 16'd1);

        // Human timeout: auto-fire after 16 cycles at (1,1)
        exp_q.push_back({2'd1, 2'd1});
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            cyc();
            if (w_req) n = i;
        end
        check("timeout_cycles", 16'(n), 16'd16);
        check("timeout_timer", 16'(w_tmr), 16'd15);
        check("timeout_est", 16'(w_est), 16'd4);
        board_done = 1'b1;
        cyc();
        board_done = 1'b0;
        cyc();
        check("back_to_cpu", 16'(w_ply), 16'd2);

        // CPU row 0 treated as 1, then player 1 wins... winner=1 ends the game
        cpu_valid = 1'b1; cpu_row = 2'd0; cpu_col = 2'd3;
        exp_q.push_back({2'd1, 2'd3});
        cyc();
        cpu_valid = 1'b0;
        check("cpu_zero_row", 16'(w_row), 16'd1);
        check("cpu_zero_col", 16'(w_col), 16'd3);
        board_done = 1'b1; winner = 2'd1;
        cyc();
        board_done = 1'b0; winner = 2'd0;
        cyc();
        check("game_over", 16'(w_est), 16'd6);
        check("game_over_player", 16'(w_ply), 16'd2);
        press(1);
        check("game_over_ignores_move", 16'(w_est), 16'd6);
        press(0);
        check("game_over_to_idle", 16'(w_est), 16'd0);
        check("idle_player", 16'(w_ply), 16'd0);

        // Two humans; select ignored in TURN; simultaneous move+attack
        press(0); press(0); press(0);
        check("human_turn", 16'(w_est), 16'd3);
        check("human_player1", 16'(w_ply), 16'd1);
        press(0);
        check("turn_ignores_select", 16'(w_est), 16'd3);
        press(1);
        check("move_col2", 16'(w_col), 16'd2);
        move = 1'b1; attack = 1'b1;
        exp_q.push_back({2'd1, 2'd2});
        cyc();
        move = 1'b0; attack = 1'b0;
        check("move_attack_est", 16'(w_est), 16'd4);
        check("move_attack_col", 16'(w_col), 16'd2);
        cyc();

        // Reset in WAIT_BOARD; a later board_done is ignored
        rst_main = 1'b1;
        cyc();
        check_reset("midreset");
        rst_main = 1'b0;
        board_done = 1'b1; winner = 2'd1;
        cyc();
        board_done = 1'b0; winner = 2'd0;
        cyc();
        check("post_reset_done_ignored", 16'(w_est), 16'd0);
        check("pending_main", 16'(exp_q.size()), 16'd0);

        // Long-timeout instance: full cursor wrap in a human player-2 turn
        rst_main = 1'b1;
        sel_long = 1'b1;
        rst_long = 1'b0;
        cyc();
        orden = 1'b1; cant = 1'b0;
        press(0); press(0); press(0);
        check("wrap_player2", 16'(w_ply), 16'd2);
        for (int i = 0; i < 9; i++) begin
            press(1);
            check("wrap_row", 16'(w_row), 16'(wrap_row[i]));
            check("wrap_col", 16'(w_col), 16'(wrap_col[i]));
        end
        exp_q.push_back({2'd1, 2'd1});
        press(2);
        check("wrap_attack_est", 16'(w_est), 16'd4);
        board_done = 1'b1; winner = 2'd2;
        cyc();
        board_done = 1'b0;
        cyc();
        check("p2_wins_est", 16'(w_est), 16'd6);
        check("p2_wins_player", 16'(w_ply), 16'd2);
        check("pending_long", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 Parameter: TURN_CYCLES, default 16, human-turn timeout in clock cycles (legal range 2..255).
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 select  input  1  menu/confirm button, level.
REQ-005 move  input  1  cursor-step button, level.
REQ-006 attack  input  1  fire button, level.
REQ-007 cant_player  input  1  0 = two humans, 1 = human vs CPU; sampled at confirm only.
REQ-008 orden  input  1  0 = player 1 starts, 1 = player 2 starts; sampled at confirm only.
REQ-009 cpu_valid  input  1  CPU engine presents a target cell this cycle.
REQ-010 cpu_row, cpu_col  input  2 each  CPU target, 1..3.
REQ-011 board_done  input  1  one-cycle pulse from board datapath: last attack applied.
REQ-012 winner  input  2  board verdict: 0 none, 1 P1, 2 P2, 3 draw; valid when board_done high.
REQ-013 attack_req  output  1  one-cycle pulse to board: apply attack at row_out/col_out.
REQ-014 row_out, col_out  output  2 each  cursor / attack target, range 1..3.
REQ-015 current_player_out  output  2  1 or 2 during play; 0 outside play.
REQ-016 estado  output  4  state encoding per REQ-020.
REQ-017 timer_out  output  8  cycles elapsed in current human turn.

Function
REQ-018 select, move, attack SHALL each be rising-edge detected via one register; only edges act; a held button produces one event.
REQ-019 Same-cycle move and attack edges: attack SHALL win, move discarded.
REQ-020 States/encoding: IDLE=0, CFG_PLAYERS=1, CFG_ORDER=2, TURN=3, WAIT_BOARD=4, CHECK=5, GAME_OVER=6; 7-15 unused, SHALL return to IDLE next cycle.
REQ-021 IDLE --select edge--> CFG_PLAYERS --select edge, latch cant_player--> CFG_ORDER --select edge, latch orden--> TURN with current player 1 if orden=0 else 2.
REQ-022 Entering TURN: cursor SHALL be (1,1), timer_out SHALL be 0.
REQ-023 Human turn (player 1, or player 2 when latched cant_player=0): move edge SHALL step col 1->2->3; from col 3 col wraps to 1 and row increments; (3,3) wraps to (1,1).
REQ-024 Human turn: attack edge SHALL assert attack_req for exactly one cycle (registered, cycle after the edge is detected) with current cursor, and state SHALL go to WAIT_BOARD in that same cycle.
REQ-025 Human turn: timer_out SHALL increment each cycle; when timer_out = TURN_CYCLES-1 with no attack edge, the block SHALL auto-fire attack_req at current cursor and go to WAIT_BOARD.
REQ-026 CPU turn (player 2, latched cant_player=1): move/attack ignored, timer held 0; on cpu_valid row_out/col_out SHALL load cpu_row/cpu_col and attack_req SHALL pulse the next cycle, then WAIT_BOARD; cpu values of 0 SHALL be treated as 1.
REQ-027 WAIT_BOARD: hold outputs, ignore buttons and cpu_valid; on board_done capture winner and go to CHECK.
REQ-028 CHECK (one cycle): captured winner != 0 -> GAME_OVER; else toggle player (1<->2) and return to TURN.
REQ-029 GAME_OVER: current_player_out SHALL hold the last mover; select edge SHALL go to IDLE; other inputs ignored.
REQ-030 select edges during TURN/WAIT_BOARD/CHECK SHALL be ignored.
REQ-031 attack_req SHALL never be high on two consecutive cycles and never outside the TURN->WAIT_BOARD transition.

Reset
REQ-032 rst high at a clock edge SHALL force, from any state: estado=0, attack_req=0, row_out=1, col_out=1, current_player_out=0, timer_out=0, latched cant_player=0, latched orden=0, edge registers=0.
REQ-033 Buttons held high across rst release SHALL NOT generate events until released and re-pressed.

Verification
REQ-034 Config: three select pulses with cant_player=1, orden=1 -> estado 1,2,3; current_player_out=2; CPU turn active.
REQ-035 Cursor wrap: human turn, 9 move pulses -> cursor (1,2),(1,3),(2,1)...(3,3),(1,1); attack -> one attack_req pulse at (1,1).
REQ-036 Timeout: TURN_CYCLES=16, no buttons -> attack_req pulse when timer_out=15, cursor (1,1), estado 4.
REQ-037 CPU: cpu_valid with cpu_row=2, cpu_col=3 -> row_out=2, col_out=3, single attack_req; board_done with winner=0 -> current_player_out=1, estado 3.
REQ-038 End and mid-game reset: board_done with winner=1 -> estado 6; select -> estado 0; rst asserted in WAIT_BOARD -> all REQ-032 values next cycle, later board_done ignored.
REQ-039 Simultaneous move+attack edge -> attack_req at unchanged cursor, no step.
